// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-bank command controller.
package spi_pkg;

   localparam int unsigned ADDR_W     = 7;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned CMD_RW_BIT = 7;

   localparam logic [BYTE_W-1:0] STATUS_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WDATA,
      ST_RFETCH,
      ST_RDATA
   } st_t;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-stream side and register-bank side of the SPI command controller.
interface spi_reg_ctrl_if;
   import spi_pkg::*;

   logic              cs_active;
   logic              rx_valid;
   logic [BYTE_W-1:0] rx_byte;
   logic              tx_load;
   logic [BYTE_W-1:0] tx_byte;
   logic [ADDR_W-1:0] reg_addr;
   logic [BYTE_W-1:0] reg_wdata;
   logic              reg_we;
   logic              reg_re;
   logic [BYTE_W-1:0] reg_rdata;
   logic              err;

   modport master (
      input  cs_active, rx_valid, rx_byte, reg_rdata,
      output tx_load, tx_byte, reg_addr, reg_wdata, reg_we, reg_re, err
   );

   modport slave (
      output cs_active, rx_valid, rx_byte, reg_rdata,
      input  tx_load, tx_byte, reg_addr, reg_wdata, reg_we, reg_re, err
   );

endinterface

// File: rtl/spi_reg_ctrl.sv
// Turns each chip-select frame of received bytes into register reads/writes
// and supplies the next transmit byte to the shift register.
module spi_reg_ctrl
   import spi_pkg::*;
#(
   parameter int unsigned       NUM_REGS    = 16,
   parameter bit                AUTO_INC    = 1'b1,
   parameter logic [BYTE_W-1:0] STATUS_BYTE = STATUS_BYTE_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   spi_reg_ctrl_if.master bus
);

   st_t               state, state_nxt;
   logic              tx_load_r, tx_load_nxt;
   logic [BYTE_W-1:0] tx_byte_r, tx_byte_nxt;
   logic [ADDR_W-1:0] reg_addr_r, reg_addr_nxt;
   logic [BYTE_W-1:0] reg_wdata_r, reg_wdata_nxt;
   logic              reg_we_r, reg_we_nxt;
   logic              reg_re_r, reg_re_nxt;
   logic              err_r, err_nxt;
   // Marks the cycle after a data byte in WDATA (write strobe slot, taken or not).
   logic              wr_slot_r, wr_slot_nxt;

   logic addr_ok;
   logic busy;
   logic rx_state;
   logic rx_take;
   logic rx_drop;

   assign addr_ok  = (32'(reg_addr_r) < NUM_REGS);
   // A byte arriving while a strobe is in flight cannot be serviced.
   assign busy     = reg_we_r | reg_re_r | tx_load_r | wr_slot_r;
   assign rx_state = (state == ST_CMD) || (state == ST_WDATA) || (state == ST_RDATA);
   assign rx_take  = bus.cs_active && bus.rx_valid && rx_state && !busy;
   assign rx_drop  = bus.cs_active && bus.rx_valid &&
                     ((rx_state && busy) || (state == ST_RFETCH));

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         tx_load_r   <= 1'b0;
         tx_byte_r   <= '0;
         reg_addr_r  <= '0;
         reg_wdata_r <= '0;
         reg_we_r    <= 1'b0;
         reg_re_r    <= 1'b0;
         err_r       <= 1'b0;
         wr_slot_r   <= 1'b0;
      end else begin
         state       <= state_nxt;
         tx_load_r   <= tx_load_nxt;
         tx_byte_r   <= tx_byte_nxt;
         reg_addr_r  <= reg_addr_nxt;
         reg_wdata_r <= reg_wdata_nxt;
         reg_we_r    <= reg_we_nxt;
         reg_re_r    <= reg_re_nxt;
         err_r       <= err_nxt;
         wr_slot_r   <= wr_slot_nxt;
      end
   end

   // Next state; chip-select deassertion overrides everything.
   always_comb begin
      state_nxt = state;
      if (!bus.cs_active) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   state_nxt = ST_CMD;
            ST_CMD:    if (rx_take) state_nxt = bus.rx_byte[CMD_RW_BIT] ? ST_RFETCH : ST_WDATA;
            ST_WDATA:  state_nxt = ST_WDATA;
            // First RFETCH cycle carries reg_re, second one sees reg_rdata.
            ST_RFETCH: if (!reg_re_r) state_nxt = ST_RDATA;
            ST_RDATA:  if (rx_take) state_nxt = ST_RFETCH;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   // Next values of strobes, address counter, data and error flag.
   always_comb begin
      tx_load_nxt   = 1'b0;
      reg_we_nxt    = 1'b0;
      reg_re_nxt    = 1'b0;
      wr_slot_nxt   = 1'b0;
      tx_byte_nxt   = tx_byte_r;
      reg_addr_nxt  = reg_addr_r;
      reg_wdata_nxt = reg_wdata_r;
      err_nxt       = err_r;
      if (bus.cs_active) begin
         if (rx_drop) err_nxt = 1'b1;
         case (state)
            ST_IDLE: begin
               tx_byte_nxt = STATUS_BYTE;
               tx_load_nxt = 1'b1;
               err_nxt     = 1'b0;
            end
            ST_CMD: begin
               if (rx_take) begin
                  reg_addr_nxt = bus.rx_byte[ADDR_W-1:0];
                  reg_re_nxt   = bus.rx_byte[CMD_RW_BIT];
               end
            end
            ST_WDATA: begin
               // Address advances only after the strobe slot so reg_addr is stable under reg_we.
               if (wr_slot_r && AUTO_INC) reg_addr_nxt = reg_addr_r + ADDR_W'(1);
               if (rx_take) begin
                  wr_slot_nxt = 1'b1;
                  if (addr_ok) begin
                     reg_we_nxt    = 1'b1;
                     reg_wdata_nxt = bus.rx_byte;
                  end else begin
                     err_nxt = 1'b1;
                  end
               end
            end
            ST_RFETCH: begin
               if (!reg_re_r) begin
                  tx_load_nxt = 1'b1;
                  if (addr_ok) begin
                     tx_byte_nxt = bus.reg_rdata;
                  end else begin
                     tx_byte_nxt = '0;
                     err_nxt     = 1'b1;
                  end
               end
            end
            ST_RDATA: begin
               if (rx_take) begin
                  if (AUTO_INC) reg_addr_nxt = reg_addr_r + ADDR_W'(1);
                  reg_re_nxt = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.tx_load   = tx_load_r;
   assign bus.tx_byte   = tx_byte_r;
   assign bus.reg_addr  = reg_addr_r;
   assign bus.reg_wdata = reg_wdata_r;
   assign bus.reg_we    = reg_we_r;
   assign bus.reg_re    = reg_re_r;
   assign bus.err       = err_r;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed frames plus random frames
// checked against a frame-level model of register reads and writes.
module tb_spi_reg_ctrl;

   typedef struct {
      int         c;
      logic [6:0] a;
      logic [7:0] d;
   } ev_t;

   logic clk;
   logic rst_n;
   logic preload;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] bank       [16];
   logic [7:0] model_bank [16];
   logic [7:0] dat        [4];

   ev_t  tx_q [$];
   ev_t  we_q [$];
   int   re_cnt = 0;
   int   overlap = 0;
   int   long_strobe = 0;
   logic prev_we = 1'b0;
   logic prev_re = 1'b0;
   logic prev_tx = 1'b0;

   spi_reg_ctrl_if bus ();

   spi_reg_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Register bank: write on reg_we, read data one cycle after reg_re.
   always @(posedge clk) begin
      if (preload) begin
         for (int k = 0; k < 16; k++) bank[k] <= 8'(8'h10 + k);
      end else if (bus.reg_we && bus.reg_addr < 7'd16) begin
         bank[bus.reg_addr[3:0]] <= bus.reg_wdata;
      end
      if (bus.reg_re) bus.reg_rdata <= (bus.reg_addr < 7'd16) ? bank[bus.reg_addr[3:0]] : 8'hEE;
   end

   // Strobe monitor, sampled away from the active edge.
   always @(negedge clk) begin
      ev_t e;
      e.c = cyc;
      e.a = bus.reg_addr;
      if (bus.tx_load === 1'b1) begin
         e.d = bus.tx_byte;
         tx_q.push_back(e);
      end
      if (bus.reg_we === 1'b1) begin
         e.d = bus.reg_wdata;
         we_q.push_back(e);
      end
      if (bus.reg_re === 1'b1) re_cnt++;
      if ((int'(bus.reg_we === 1'b1) + int'(bus.reg_re === 1'b1) + int'(bus.tx_load === 1'b1)) > 1)
         overlap++;
      if ((bus.reg_we === 1'b1 && prev_we) || (bus.reg_re === 1'b1 && prev_re) ||
          (bus.tx_load === 1'b1 && prev_tx))
         long_strobe++;
      prev_we = (bus.reg_we === 1'b1);
      prev_re = (bus.reg_re === 1'b1);
      prev_tx = (bus.tx_load === 1'b1);
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, output int c);
      bus.rx_byte  = b;
      bus.rx_valid = 1'b1;
      c = cyc;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   function automatic int gap();
      return int'($urandom_range(4, 9));
   endfunction

   // Raise chip-select and expect the status byte one cycle later with err cleared.
   task automatic frame_start();
      int s, txb;
      txb = tx_q.size();
      s = cyc;
      bus.cs_active = 1'b1;
      tick(1);
      #1;
      chk("start_tx_cnt", tx_q.size() - txb, 1);
      if (tx_q.size() > txb) begin
         chk("start_tx_cyc", tx_q[txb].c, s + 1);
         chk("start_tx_byte", tx_q[txb].d, 8'hA5);
      end
      chk("start_err", bus.err, 1'b0);
   endtask

   // One complete frame: command byte plus n data/dummy bytes, checked against the model.
   task automatic do_frame(input logic [7:0] cmd, input int n);
      int         rc [5];
      int         txb, web, reb, nwe;
      logic [6:0] aa;
      logic [7:0] exp_b;
      logic       exp_err;
      ev_t        e;
      frame_start();
      txb = tx_q.size();
      web = we_q.size();
      reb = re_cnt;
      tick(gap());
      send(cmd, rc[0]);
      for (int i = 0; i < n; i++) begin
         tick(gap());
         send(dat[i], rc[i+1]);
      end
      tick(6);
      #1;
      exp_err = 1'b0;
      nwe = 0;
      if (!cmd[7]) begin
         for (int i = 0; i < n; i++) begin
            aa = cmd[6:0] + 7'(i);
            if (aa < 7'd16) begin
               if (we_q.size() > web + nwe) begin
                  e = we_q[web + nwe];
                  chk("wr_addr", e.a, aa);
                  chk("wr_data", e.d, dat[i]);
                  chk("wr_cyc", e.c, rc[i+1] + 1);
               end
               model_bank[aa[3:0]] = dat[i];
               nwe++;
            end else begin
               exp_err = 1'b1;
            end
         end
         chk("wr_cnt", we_q.size() - web, nwe);
         chk("wr_no_re", re_cnt - reb, 0);
         chk("wr_no_tx", tx_q.size() - txb, 0);
      end else begin
         for (int i = 0; i <= n; i++) begin
            aa = cmd[6:0] + 7'(i);
            if (aa < 7'd16) begin
               exp_b = model_bank[aa[3:0]];
            end else begin
               exp_b = 8'h00;
               exp_err = 1'b1;
            end
            if (tx_q.size() > txb + i) begin
               chk("rd_byte", tx_q[txb+i].d, exp_b);
               chk("rd_latency", tx_q[txb+i].c, rc[i] + 3);
            end
         end
         chk("rd_tx_cnt", tx_q.size() - txb, n + 1);
         chk("rd_re_cnt", re_cnt - reb, n + 1);
         chk("rd_no_we", we_q.size() - web, 0);
      end
      chk("frame_err", bus.err, exp_err);
      bus.cs_active = 1'b0;
      tick(2);
   endtask

   initial begin
      int         c0, c1, c2, txb, reb, web, n;
      logic [6:0] a;
      logic       rw;

      rst_n         = 1'b0;
      preload       = 1'b1;
      bus.cs_active = 1'b0;
      bus.rx_valid  = 1'b0;
      bus.rx_byte   = 8'h00;
      bus.reg_rdata = 8'h00;
      for (int k = 0; k < 16; k++) model_bank[k] = 8'(8'h10 + k);
      tick(3);
      #1;
      chk("rst_tx_load", bus.tx_load, 1'b0);
      chk("rst_tx_byte", bus.tx_byte, 8'h00);
      chk("rst_reg_addr", bus.reg_addr, 7'h00);
      chk("rst_reg_wdata", bus.reg_wdata, 8'h00);
      chk("rst_reg_we", bus.reg_we, 1'b0);
      chk("rst_reg_re", bus.reg_re, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      tick(1);
      preload = 1'b0;
      rst_n   = 1'b1;
      tick(2);

      // Burst read from preloaded bank: 15,16,17,18.
      do_frame(8'h85, 3);

      // Single write reg3 = 5C.
      dat[0] = 8'h5C;
      do_frame(8'h03, 1);

      // Reset while reg_re is high.
      frame_start();
      tick(5);
      send(8'h81, c0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_reg_re", bus.reg_re, 1'b0);
      chk("midrst_tx_load", bus.tx_load, 1'b0);
      chk("midrst_reg_we", bus.reg_we, 1'b0);
      chk("midrst_reg_addr", bus.reg_addr, 7'h00);
      chk("midrst_tx_byte", bus.tx_byte, 8'h00);
      chk("midrst_reg_wdata", bus.reg_wdata, 8'h00);
      chk("midrst_err", bus.err, 1'b0);
      bus.cs_active = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(2);

      // Out-of-range write then wrap to reg0.
      dat[0] = 8'hEE;
      dat[1] = 8'h11;
      do_frame(8'h7F, 2);

      // Out-of-range read returns 00 and flags err; next frame clears it.
      do_frame(8'h90, 0);

      // Read back regs 0..3.
      do_frame(8'h80, 3);

      // Chip-select drops during the fetch: no transmit load.
      frame_start();
      txb = tx_q.size();
      reb = re_cnt;
      tick(5);
      send(8'h82, c0);
      bus.cs_active = 1'b0;
      tick(5);
      #1;
      chk("abort_no_tx", tx_q.size() - txb, 0);
      chk("abort_re_cnt", re_cnt - reb, 1);

      // Two back-to-back bytes in RDATA: second dropped.
      frame_start();
      txb = tx_q.size();
      reb = re_cnt;
      tick(5);
      send(8'h84, c0);
      tick(6);
      send(8'hFF, c1);
      send(8'hFF, c2);
      tick(6);
      #1;
      chk("ovr_tx_cnt", tx_q.size() - txb, 2);
      if (tx_q.size() >= txb + 2) begin
         chk("ovr_tx0", tx_q[txb].d, model_bank[4]);
         chk("ovr_tx1", tx_q[txb+1].d, model_bank[5]);
         chk("ovr_tx1_cyc", tx_q[txb+1].c, c1 + 3);
      end
      chk("ovr_re_cnt", re_cnt - reb, 2);
      chk("ovr_err", bus.err, 1'b1);
      bus.cs_active = 1'b0;
      tick(2);

      // Chip-select falls together with a data byte: byte discarded.
      frame_start();
      web = we_q.size();
      tick(5);
      send(8'h02, c0);
      tick(5);
      bus.cs_active = 1'b0;
      send(8'h77, c1);
      tick(3);
      #1;
      chk("csfall_no_we", we_q.size() - web, 0);
      chk("csfall_err", bus.err, 1'b0);

      // Random frames.
      for (int f = 0; f < 16; f++) begin
         a  = ($urandom_range(0, 7) == 0) ? 7'(7'h7E + $urandom_range(0, 1))
                                          : 7'($urandom_range(0, 19));
         rw = 1'($urandom_range(0, 1));
         n  = rw ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 4));
         for (int k = 0; k < 4; k++) dat[k] = 8'($urandom_range(0, 255));
         do_frame({rw, a}, n);
      end

      chk("strobe_overlap", overlap, 0);
      chk("strobe_width", long_strobe, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command/transaction controller behind the SPI slave shift register.
- Turns the received byte stream of each chip-select frame into register-bank reads and writes.
- Supplies the next transmit byte to the shift register.
- Sits between the SPI byte interface and the design's register bank, inside tt_um_sergejsumnovs_spi_slave, all in the system clock domain.

Parameters:
- NUM_REGS, 16, number of implemented registers; addresses >= NUM_REGS are out of range.
- AUTO_INC, 1, 1 = address increments after each data byte in a frame; 0 = address held.
- STATUS_BYTE, 8'hA5, byte loaded for transmission during the command byte.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cs_active  in  1  synchronized chip-select, 1 = frame in progress.
- rx_valid  in  1  one-cycle strobe: rx_byte holds a complete received byte.
- rx_byte  in  8  received byte.
- tx_load  out  1  one-cycle strobe: shift register loads tx_byte.
- tx_byte  out  8  byte to transmit next.
- reg_addr  out  7  register address.
- reg_wdata  out  8  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data, valid exactly one cycle after reg_re.
- err  out  1  sticky error flag, cleared at frame start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; reg_addr=0, reg_wdata=0, tx_byte=0, err=0.
  - tx_load=0, reg_we=0, reg_re=0.
- States: IDLE, CMD, WDATA, RFETCH, RDATA.
- cs_active=0 in any state: next cycle state=IDLE.
  - A pending RFETCH is abandoned with no tx_load.
  - Registered outputs hold; all strobes 0.
- IDLE, cs_active=1 (frame start), next cycle:
  - state=CMD, tx_byte=STATUS_BYTE, tx_load=1, err=0.
- CMD, on rx_valid:
  - reg_addr <= rx_byte[6:0].
  - rx_byte[7]=0 (write): state=WDATA.
  - rx_byte[7]=1 (read): reg_re=1 next cycle, state=RFETCH.
- WDATA, on rx_valid:
  - Address in range: next cycle reg_we=1, reg_wdata=rx_byte, reg_addr unchanged during the strobe.
  - Out of range: no reg_we, err=1.
  - The cycle after the strobe slot, reg_addr increments if AUTO_INC=1.
  - Remains in WDATA.
- RFETCH (reg_re high this cycle), next cycle:
  - tx_byte = reg_rdata if address in range, else 8'h00 and err=1.
  - tx_load=1, state=RDATA.
- Read latency: rx_valid of the command byte -> tx_load exactly 3 cycles later.
- RDATA, on rx_valid (dummy byte; previous tx byte has been shifted):
  - If AUTO_INC=1, reg_addr increments.
  - reg_re=1 next cycle, state=RFETCH.
  - Same 3-cycle latency as the command byte.
- Address arithmetic: 7-bit; 7'h7F+1 wraps to 7'h00.
- rx_valid while in RFETCH, or while a strobe is pending: byte dropped, err=1, state unchanged.
- rx_valid in IDLE: ignored.
- Simultaneous cs_active falling and rx_valid: the cs deassertion wins, the byte is discarded, no strobe.
- Strobes never overlap: reg_we, reg_re and tx_load are mutually exclusive and each lasts one cycle.
- reset mid-frame: immediate IDLE; strobes drop asynchronously.

Decomposition:
- Shared package spi_pkg holds:
  - state enum (st_t);
  - CMD_RW_BIT = 7;
  - ADDR_W = 7, BYTE_W = 8;
  - default STATUS_BYTE.
- Single module; no sub-module is warranted.
- The address counter stays inline.

Test Plan:
- Reset and frame start:
  - assert rst_n=0 mid-operation -> all outputs 0;
  - cs_active 0->1 -> tx_load with tx_byte=8'hA5 one cycle later, err=0.
- Single write:
  - cmd 8'h03, data 8'h5C -> reg_we=1 one cycle after the data rx_valid, reg_addr=3, reg_wdata=8'h5C;
  - no reg_re.
- Burst read, AUTO_INC=1:
  - bank preloaded with reg[k]=8'h10+k; cmd 8'h85, then 3 dummy bytes;
  - -> tx_byte 8'h15, 8'h16, 8'h17, 8'h18, each tx_load 3 cycles after the corresponding rx_valid.
- Out-of-range and wrap:
  - cmd 8'h7F write 8'hEE, then 8'h11 -> no reg_we for addr 7F, err=1;
  - second byte writes reg 0 = 8'h11.
- Read out of range:
  - cmd 8'h90 -> tx_byte=8'h00, err=1;
  - next frame start clears err.
- Abort and overrun:
  - cs_active drops during RFETCH -> no tx_load, state IDLE.
  - rx_valid pulses on two consecutive cycles in RDATA -> second dropped, err=1, only one reg_re.
